// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table extractor.
// Also holds the hex-signature parser used when writing benches.
package tt_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} tt_state_e;

    localparam int unsigned N_IN_DEF = 7;
    localparam int unsigned CNT_W    = 4;

    function automatic int unsigned tt_width(input int unsigned n_in);
        return 1 << n_in;
    endfunction

    localparam int unsigned TT_W_DEF = tt_width(N_IN_DEF);

    // The first character of the signature is the most significant hex digit; '_' is skipped.
    function automatic logic [TT_W_DEF-1:0] tt_from_hex(input string sig);
        logic [TT_W_DEF-1:0] v;
        logic [7:0]          c;
        logic [3:0]          d;
        v = '0;
        for (int unsigned i = 0; i < unsigned'(sig.len()); i++) begin
            c = sig[i];
            d = '0;
            if (c >= 8'h30 && c <= 8'h39)      d = 4'(c - 8'h30);
            else if (c >= 8'h61 && c <= 8'h66) d = 4'(c - 8'h57);
            else if (c >= 8'h41 && c <= 8'h46) d = 4'(c - 8'h37);
            else continue;
            v = {v[TT_W_DEF-5:0], d};
        end
        return v;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long a pattern is held before sampling.
module tt_settle_timer
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    // A load of SETTLE_CYCLES-1 makes the zero flag appear on the last settle cycle.
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tt_extractor.sv
// Sweeps every input pattern into an attached network and assembles its truth table,
// optionally comparing it against a reference table.
module tt_extractor
    import tt_pkg::*;
#(
    parameter  int unsigned N_IN          = 7,
    parameter  int unsigned SETTLE_CYCLES = 1,
    localparam int unsigned TT_W          = tt_width(N_IN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            f_out,
    output logic [N_IN-1:0] x,
    output logic            busy,
    output logic [TT_W-1:0] tt,
    output logic            tt_valid,
    input  logic            tt_ready,
    input  logic [TT_W-1:0] expected_tt,
    output logic            match
);

    localparam bit              SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [N_IN-1:0] IDX_LAST    = '1;
    localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1);

    tt_state_e       r_state;
    tt_state_e       w_next;
    logic [N_IN-1:0] r_idx;
    logic [TT_W-1:0] r_tt;
    logic            r_tt_valid;
    logic            r_match;
    logic            w_load;
    logic            w_zero;
    logic            w_last;

    assign w_last = (r_idx == IDX_LAST);

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .i_clk (clk),
        .i_rst (rst),
        .i_load(w_load),
        .i_en  (r_state == SETTLE),
        .o_zero(w_zero)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = SKIP_SETTLE ? SAMPLE : SETTLE;
                    w_load = 1'b1;
                end
            end
            SETTLE: begin
                if (abort)       w_next = IDLE;
                else if (w_zero) w_next = SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = SKIP_SETTLE ? SAMPLE : SETTLE;
                    w_load = 1'b1;
                end
            end
            DONE: begin
                if (r_tt_valid && tt_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // tt_valid rises one edge after DONE is entered, giving 1 + TT_W*(SETTLE_CYCLES+1) edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_tt       <= '0;
            r_tt_valid <= 1'b0;
            r_match    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        r_tt  <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        r_idx <= '0;
                        r_tt  <= '0;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        r_idx <= '0;
                        r_tt  <= '0;
                    end else begin
                        r_tt[r_idx] <= f_out;
                        if (w_last) r_match <= ({f_out, r_tt[TT_W-2:0]} == expected_tt);
                        else        r_idx   <= r_idx + IDX_ONE;
                    end
                end
                DONE: begin
                    if (!r_tt_valid)    r_tt_valid <= 1'b1;
                    else if (tt_ready)  r_tt_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign x        = (r_state == IDLE) ? '0 : r_idx;
    assign busy     = (r_state == SETTLE) || (r_state == SAMPLE);
    assign tt       = r_tt;
    assign tt_valid = r_tt_valid;
    assign match    = r_match;

endmodule

// File: doc/tt_extractor.md
Name: tt_extractor

Overview:
- Sequential truth-table reader for the team's 7-input majority-gate function networks.
- Drives every input pattern x0..x6 into an attached combinational network, waits a programmable settle time, then samples the network's `out`.
- Assembles the full 2^N-bit truth table, using the same hex signature ordering the team uses for function names.
- Optionally compares the result against an expected table, so netlists can be checked in silicon or in emulation.

Parameters:
- N_IN, 7, number of function inputs; truth-table width TT_W = 2**N_IN.
- SETTLE_CYCLES, 1, clock cycles the pattern is held before sampling; legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE
- abort  input  1  cancels a sweep in progress
- f_out  input  1  output of the network under test (the network's `out`)
- x  output  N_IN  pattern driven to the network; x[0] maps to x0 … x[6] maps to x6
- busy  output  1  high in SETTLE and SAMPLE
- tt  output  TT_W  captured truth table
- tt_valid  output  1  result available
- tt_ready  input  1  consumer accepts the result
- expected_tt  input  TT_W  reference table; must be stable while tt_valid is high
- match  output  1  registered (tt == expected_tt); meaningful only while tt_valid is high

Behaviour:
- Reset (async, active-high) sets: state=IDLE, x=0, idx=0, cnt=0, tt=0, tt_valid=0, match=0, busy=0.
- Bit ordering: tt[i] = f_out sampled while x == i. tt[TT_W-1:TT_W-4] is the first hex digit of the signature string.
- States are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - x=0.
  - start=1 → idx=0, cnt=0, tt=0, next state SETTLE.
- SETTLE:
  - x=idx; cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1 → SAMPLE.
  - If SETTLE_CYCLES==0, SETTLE is skipped: IDLE/SAMPLE go directly to SAMPLE.
- SAMPLE:
  - x=idx; tt[idx] <= f_out.
  - If idx == TT_W-1 → DONE, and match <= ({f_out, tt[TT_W-2:0]} == expected_tt).
  - Otherwise idx++, cnt=0 → SETTLE.
- DONE:
  - tt_valid=1; x held at TT_W-1.
  - tt, tt_valid and match stay stable until tt_ready=1.
  - On tt_ready=1 → IDLE, tt_valid=0. tt keeps its value until the next start.
- Timing:
  - Each pattern occupies SETTLE_CYCLES+1 cycles.
  - tt_valid rises exactly 1 + TT_W*(SETTLE_CYCLES+1) clock edges after the edge that accepted start.
  - With defaults this is 257 edges.
- idx is N_IN bits wide; the terminal test occurs before increment, so there is no wrap-around.
- start outside IDLE is ignored, including in DONE.
- abort in SETTLE or SAMPLE → IDLE next edge, with tt=0, tt_valid=0, x=0. abort in IDLE or DONE is ignored.
- Simultaneous abort and start in IDLE: start wins; abort is ignored there.
- Reset mid-sweep: immediate return to reset values; no partial result is ever flagged valid.

Decomposition:
- Package tt_pkg contains:
  - state enum tt_state_e {IDLE, SETTLE, SAMPLE, DONE};
  - constant TT_W derivation;
  - a hex-signature-to-vector helper function for benches.
- One sub-module, tt_settle_timer: loadable down-counter, SETTLE_CYCLES wide, with a `zero` flag. The main FSM stays in tt_extractor.

Test Plan:
- f_out = x[0]&x[1], defaults → tt = 0x8888_8888_8888_8888_8888_8888_8888_8888; tt_valid rises 257 edges after start.
- f_out = x[6], expected_tt = 0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000 → match=1. Flip expected bit 0 → match=0.
- f_out tied 0 and then tied 1, SETTLE_CYCLES=0 → tt all 0 then all F; tt_valid rises 129 edges after start; x steps 0..127 one value per cycle.
- abort at idx=40, then start again with f_out=1 → tt_valid never asserted for the aborted run; second run gives all-F.
- Hold tt_ready=0 for 20 cycles in DONE, pulsing start → tt, match and tt_valid stable; start ignored; IDLE only after tt_ready.
- Assert rst asynchronously mid-SETTLE (between clock edges) → all outputs return to reset values immediately, with no clock edge required.
